// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared SECDED Hamming helpers for the encoder pipeline and the decoder bench.
// Codeword layout: hamming position p (1-based) lives at bit p-1; positions that
// are powers of two hold parity, the rest hold data bits in ascending order.
// The overall (even) parity bit sits just above the hamming field.
// hamming_encode() works on a MAX_DW-wide container with the real data width
// passed in, so any width up to MAX_DW shares one implementation.
// -----------------------------------------------------------------------------
package hamming_pkg;

  localparam int MAX_DW = 32;

  function automatic int parity_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

  function automatic int enc_width(input int dw);
    return dw + parity_width(dw);
  endfunction

  localparam int MAX_PW  = parity_width(MAX_DW);
  localparam int MAX_ENC = enc_width(MAX_DW);
  localparam int MAX_CW  = MAX_ENC + 1;

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) carrying data bit n: the n-th position that is
  // not a power of two, counting from 0.
  function automatic int data_to_pos(input int n);
    int cnt;
    int result;
    cnt    = 0;
    result = 0;
    for (int p = 3; p < 64; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == n && result == 0) result = p;
        cnt++;
      end
    end
    return result;
  endfunction

  // Even-parity SECDED codeword for the low dw bits of data. Bits above
  // enc_width(dw) are returned as zero.
  function automatic logic [MAX_CW-1:0] hamming_encode(input logic [MAX_DW-1:0] data,
                                                       input int dw);
    logic [MAX_CW-1:0] cw;
    logic              par;
    int                ew;
    cw = '0;
    ew = enc_width(dw);
    for (int n = 0; n < MAX_DW; n++) begin
      if (n < dw) cw[data_to_pos(n) - 1] = data[n];
    end
    // Parity bits only cover data positions, so their own slots (still zero
    // here) never feed back into the XOR.
    for (int i = 0; i < MAX_PW; i++) begin
      if (i < parity_width(dw)) begin
        par = 1'b0;
        for (int p = 1; p <= MAX_ENC; p++) begin
          if (p <= ew && ((p >> i) & 1) == 1) par ^= cw[p - 1];
        end
        cw[(1 << i) - 1] = par;
      end
    end
    par = 1'b0;
    for (int p = 0; p < MAX_ENC; p++) begin
      if (p < ew) par ^= cw[p];
    end
    cw[ew] = par;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// -----------------------------------------------------------------------------
// hamming_parity_gen
// Combinational data -> SECDED codeword (hamming field plus overall parity).
// Ports:
//   data      in  DATA_WIDTH                raw data word
//   codeword  out enc_width(DATA_WIDTH)+1    encoded word, decoder layout
// -----------------------------------------------------------------------------
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]          data,
  output logic [enc_width(DATA_WIDTH):0] codeword
);

  localparam int CW_WIDTH = enc_width(DATA_WIDTH) + 1;

  logic [MAX_CW-1:0] full_cw;

  always_comb begin
    full_cw  = hamming_encode(MAX_DW'(data), DATA_WIDTH);
    codeword = full_cw[CW_WIDTH-1:0];
  end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// -----------------------------------------------------------------------------
// hamming_encoder_pipe
// Two-stage valid/ready SECDED encoder with one-shot error injection.
// Stage 1 registers the raw word, stage 2 registers the (optionally corrupted)
// codeword. Full throughput, two cycles from accept to o_valid.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid/i_data      upstream word, o_ready accepts it
//   o_valid/o_enc_data  codeword out, taken when i_ready is high
//   i_inj_req/i_inj_mask arm an XOR mask for the next stage-1->2 transfer
//   o_inj_pending       mask armed and not yet applied
//   o_word_cnt          words accepted at the input, wrapping
// -----------------------------------------------------------------------------
module hamming_encoder_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_ready,
  output logic                           o_valid,
  output logic [enc_width(DATA_WIDTH):0] o_enc_data,
  input  logic                           i_ready,
  input  logic                           i_inj_req,
  input  logic [enc_width(DATA_WIDTH):0] i_inj_mask,
  output logic                           o_inj_pending,
  output logic [CNT_WIDTH-1:0]           o_word_cnt
);

  localparam int CW_WIDTH = enc_width(DATA_WIDTH) + 1;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CW_WIDTH-1:0]   inj_mask;
  logic [CW_WIDTH-1:0]   codeword;
  logic                  s2_ready;
  logic                  s1_accept;
  logic                  xfer;

  // Each stage can load when it is empty or its content leaves this cycle,
  // so a full pipeline still moves one word per cycle.
  assign s2_ready  = !o_valid || i_ready;
  assign o_ready   = !s1_valid || s2_ready;
  assign s1_accept = i_valid && o_ready;
  assign xfer      = s1_valid && s2_ready;

  hamming_parity_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_gen (
    .data    (s1_data),
    .codeword(codeword)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would make update order matter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid      <= 1'b0;
      o_valid       <= 1'b0;
      o_enc_data    <= '0;
      o_inj_pending <= 1'b0;
      inj_mask      <= '0;
      o_word_cnt    <= '0;
    end else begin
      // When o_ready is high the stage-1 word either left or was absent.
      if (o_ready) s1_valid <= i_valid;
      if (s1_accept) o_word_cnt <= o_word_cnt + CNT_WIDTH'(1);
      if (s2_ready) o_valid <= s1_valid;
      // The mask read here is the pre-edge one, so a request landing on the
      // same edge stays pending for the following word.
      if (xfer) o_enc_data <= codeword ^ (o_inj_pending ? inj_mask : '0);
      if (i_inj_req) begin
        inj_mask      <= i_inj_mask;
        o_inj_pending <= 1'b1;
      end else if (xfer) begin
        o_inj_pending <= 1'b0;
      end
    end
  end

  // NOTE: the stage-1 data register is left out of reset; its contents are
  // only consumed while s1_valid is set, which reset does clear.
  always_ff @(posedge i_clk) begin
    if (s1_accept) s1_data <= i_data;
  end

endmodule
